wb_ram_burst: RTL and testbench
===============================

// Module: wb_ram_burst
// PURPOSE
//  Parametrised on-chip RAM slave on the Wishbone bus; next generation of the single-word RAM slave.
//  Adds configurable width/depth, programmable first-beat wait states, and Wishbone registered-feedback
//  incrementing bursts (CTI/BTE) with one beat per cycle. Out-of-range accesses get an error response.
//  Sits on the system bus beside other peripherals; the CPU uses it as instruction/data scratch memory.
// PARAMETERS
//  DW           32   data width in bits; multiple of 8
//  AW           12   word-address width; DEPTH = 2**AW words
//  WAIT_STATES  0    extra cycles before the first ack of every cycle (0..15)
//  BASE_LSB     2    adr_i bit holding word-address bit 0 (= log2(DW/8))
// PORTS
//  clk_i    in   1      system clock, all logic on rising edge
//  rst_n_i  in   1      asynchronous active-low reset
//  cyc_i    in   1      Wishbone bus-cycle valid
//  stb_i    in   1      Wishbone strobe
//  we_i     in   1      1 = write, 0 = read
//  sel_i    in   DW/8   byte enables; bit n covers dat bits [8n+7:8n]
//  adr_i    in   32     byte address
//  dat_i    in   DW     write data
//  cti_i    in   3      cycle type: 000 classic, 010 incr burst, 111 end of burst
//  bte_i    in   2      burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//  dat_o    out  DW     read data, valid while ack_o=1 on a read
//  ack_o    out  1      normal termination
//  err_o    out  1      error termination (address out of range)
// BEHAVIOUR
//  Reset: ack_o=0, err_o=0, dat_o=0, FSM=IDLE, counters=0. Async assert mid-cycle abandons the cycle;
//   RAM contents are preserved. Deassertion is synchronised externally.
//  cs = cyc_i & stb_i. Range check: adr_i[31:BASE_LSB+AW] != 0 -> out of range.
//  FSM states: IDLE, WAIT, BEAT, ERR.
//   IDLE: cs & out-of-range -> ERR. cs & in-range -> WAIT if WAIT_STATES>0, else BEAT.
//    The word address is loaded into the burst pointer; the RAM read is issued in the same cycle.
//   WAIT: count WAIT_STATES cycles (count 0..WAIT_STATES-1), then BEAT. cyc_i=0 -> IDLE.
//   ERR: err_o=1 for exactly one cycle, no RAM write; -> IDLE.
//   BEAT: ack_o=1 while cs. A write commits only when ack_o & cs & we_i, byte-masked by sel_i.
//    Classic (cti 000) or end-of-burst (cti 111): single ack, then -> IDLE. Master must present a new strobe.
//    Incr burst (cti 010): pointer advances each acked beat; next RAM read issues at the advanced pointer.
//     Result: ack on consecutive cycles, zero bubbles. Wait states apply to the first beat only.
//    Wrap: bte selects low 2/3/4 pointer bits wrapping, upper bits held. Linear wraps at DEPTH-1 -> 0
//     (no error).
//    stb_i=0 inside burst (cyc_i=1): ack_o=0, pointer and dat_o held; resume on stb_i=1 with no extra latency.
//    cyc_i=0 any time: -> IDLE next cycle, ack_o=0, no write in that cycle.
//  Read latency: WAIT_STATES+1 cycles from first strobe to ack; 1 beat/cycle thereafter.
//  Read-after-write in a burst to the same word returns new data (write-first RAM).
//  Unsupported cti (001, 011..110) is treated as classic.
//  ack_o and err_o are never both 1.
// STRUCTURE
//  Package wb_pkg: CTI_CLASSIC/CTI_INCR/CTI_EOB, BTE_LINEAR/WRAP4/WRAP8/WRAP16, FSM state encoding.
//  Sub-module ram_sp_be: single-port sync RAM, parameters DW and AW, byte write enables, write-first,
//   1-cycle read.
//  Top level: FSM, wait counter, burst-pointer/wrap logic, range check, output registers.
// TESTING
//  Reset: hold rst_n_i=0 mid-burst -> ack_o/err_o/dat_o 0 at once; a prior-written word still reads back.
//  Classic: write 0xDEADBEEF @0x10 with sel=1111, then read @0x10 -> ack 1 cycle after stb, dat_o=0xDEADBEEF.
//  Byte enables: sel=0010 writes 0x0000AA00 over 0x11223344 -> read returns 0x1122AA44.
//  Burst: WAIT_STATES=2, wrap4 read from word 6 with cti 010x3 then 111 -> ack on cycles 3..6; words 6,7,4,5.
//  Abort/stall: drop stb_i 2 cycles mid-burst -> no ack, pointer held; drop cyc_i -> IDLE, no write.
//  Error: adr_i=0x0001_0000 with AW=12 -> err_o 1 cycle, ack_o=0, RAM unchanged.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle/burst type codes and the RAM slave FSM states.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BEAT,
        ST_ERR
    } wb_state_t;

    // Low pointer bits that take part in the increment for a wrapping burst.
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        case (bte)
            BTE_WRAP4:  wrap_mask = 4'h3;
            BTE_WRAP8:  wrap_mask = 4'h7;
            BTE_WRAP16: wrap_mask = 4'hF;
            default:    wrap_mask = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/ram_sp_be.sv
// Single-port synchronous RAM with byte write enables, write-first, one-cycle read.
module ram_sp_be #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [DW/8-1:0]   we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DW-1:0]     wdata_i,
    output logic [DW-1:0]     rdata_o
);

    localparam int unsigned NB = DW / 8;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] merged;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (we_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        merged = mem[addr_i];
        for (int unsigned b = 0; b < NB; b++) begin
            if (we_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
        end
    end

    // Output register holds its value whenever the port is not enabled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)  rdata_o <= '0;
        else if (en_i) rdata_o <= merged;
    end

endmodule

// File: rtl/wb_ram_burst.sv
// Wishbone RAM slave with first-beat wait states, CTI/BTE incrementing bursts
// and error termination for addresses beyond the RAM depth.
module wb_ram_burst
    import wb_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 12,
    parameter int WAIT_STATES = 0,
    parameter int BASE_LSB    = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [DW/8-1:0]   sel_i,
    input  logic [31:0]       adr_i,
    input  logic [DW-1:0]     dat_i,
    input  logic [2:0]        cti_i,
    input  logic [1:0]        bte_i,
    output logic [DW-1:0]     dat_o,
    output logic              ack_o,
    output logic              err_o
);

    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    wb_state_t       state, state_nx;
    logic            cs, out_of_range, load_ptr, adv_ptr;
    logic [AW-1:0]   adr_word, ptr, ptr_inc, ptr_nx, wmask;
    logic [3:0]      wcnt;
    logic            ram_en;
    logic [DW/8-1:0] ram_we;
    logic [AW-1:0]   ram_addr;
    logic            unused_adr_lsb;

    assign cs             = cyc_i & stb_i;
    assign adr_word       = adr_i[BASE_LSB +: AW];
    assign out_of_range   = (adr_i >> (BASE_LSB + AW)) != '0;
    assign unused_adr_lsb = ^adr_i[BASE_LSB-1:0];

    // Only the masked low bits advance; the rest of the pointer is held.
    assign wmask   = (bte_i == BTE_LINEAR) ? '1 : AW'(wrap_mask(bte_i));
    assign ptr_inc = ptr + AW'(1);
    assign ptr_nx  = (ptr & ~wmask) | (ptr_inc & wmask);

    always_comb begin
        state_nx = state;
        ram_en   = 1'b0;
        ram_we   = '0;
        ram_addr = ptr;
        load_ptr = 1'b0;
        adv_ptr  = 1'b0;
        case (state)
            ST_IDLE: begin
                ram_addr = adr_word;
                if (cs) begin
                    if (out_of_range) begin
                        state_nx = ST_ERR;
                    end else begin
                        ram_en   = 1'b1;
                        load_ptr = 1'b1;
                        state_nx = (WAIT_STATES > 0) ? ST_WAIT : ST_BEAT;
                    end
                end
            end
            ST_WAIT: begin
                ram_en = 1'b1;
                if (!cyc_i)               state_nx = ST_IDLE;
                else if (wcnt == WS_LAST) state_nx = ST_BEAT;
            end
            ST_BEAT: begin
                if (!cyc_i) begin
                    state_nx = ST_IDLE;
                end else if (stb_i) begin
                    if (we_i) begin
                        ram_en = 1'b1;
                        ram_we = sel_i;
                    end
                    case (cti_i)
                        CTI_INCR: begin
                            adv_ptr = 1'b1;
                            // Prefetch the next beat so acks run back to back.
                            if (!we_i) begin
                                ram_en   = 1'b1;
                                ram_addr = ptr_nx;
                            end
                        end
                        CTI_CLASSIC, CTI_EOB: state_nx = ST_IDLE;
                        default:              state_nx = ST_IDLE;
                    endcase
                end
            end
            ST_ERR:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
            wcnt  <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= (state == ST_WAIT && state_nx == ST_WAIT) ? wcnt + 4'd1 : '0;
            if (load_ptr)     ptr <= adr_word;
            else if (adv_ptr) ptr <= ptr_nx;
        end
    end

    assign ack_o = (state == ST_BEAT) & cs;
    assign err_o = (state == ST_ERR);

    ram_sp_be #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (dat_i),
        .rdata_o (dat_o)
    );

endmodule

// File: tb/tb_wb_ram_burst.sv
// Directed bench: a zero-wait-state slave and a two-wait-state slave sharing one bus driver.
module tb_wb_ram_burst;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic [2:0]  cti;
    logic [1:0]  bte;
    int          tgt;

    logic        cyc0, cyc2, ack0, ack2, err0, err2, ack_t, err_t;
    logic [31:0] dat0, dat2, dat_t;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign cyc0  = cyc & (tgt == 0);
    assign cyc2  = cyc & (tgt == 2);
    assign ack_t = (tgt == 0) ? ack0 : ack2;
    assign err_t = (tgt == 0) ? err0 : err2;
    assign dat_t = (tgt == 0) ? dat0 : dat2;

    wb_ram_burst #(.DW(32), .AW(12), .WAIT_STATES(0), .BASE_LSB(2)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc0), .stb_i(stb), .we_i(we),
        .sel_i(sel), .adr_i(adr), .dat_i(dat), .cti_i(cti), .bte_i(bte),
        .dat_o(dat0), .ack_o(ack0), .err_o(err0)
    );

    wb_ram_burst #(.DW(32), .AW(12), .WAIT_STATES(2), .BASE_LSB(2)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc2), .stb_i(stb), .we_i(we),
        .sel_i(sel), .adr_i(adr), .dat_i(dat), .cti_i(cti), .bte_i(bte),
        .dat_o(dat2), .ack_o(ack2), .err_o(err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_idle(input int n);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Classic single access; lat = cycles from strobe to termination, -1 on timeout.
    task automatic access(input int t, input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
        tgt = t; cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
        cti = 3'b000; bte = 2'b00; lat = -1; rd = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (ack_t || err_t) begin
                lat = c;
                rd  = dat_t;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input int t, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        access(t, 1'b1, a, s, d, rd, lat);
        check($sformatf("wr lat t%0d @%08h", t, a), 32'(lat), (t == 0) ? 32'd1 : 32'd3);
    endtask

    task automatic rd_chk(input string tag, input int t, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        access(t, 1'b0, a, 4'hF, 32'h0, rd, lat);
        check({tag, " lat"}, 32'(lat), (t == 0) ? 32'd1 : 32'd3);
        check({tag, " data"}, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_dat [8];
        logic        exp_ack [8];

        rst_n = 1'b0; tgt = 0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; dat = '0; cti = 3'b000; bte = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ack0", {31'd0, ack0}, 32'd0);
        check("reset err0", {31'd0, err0}, 32'd0);
        check("reset dat0", dat0, 32'h0);
        check("reset ack2", {31'd0, ack2}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_idle(2);

        // Classic write/read, zero wait states
        wr(0, 32'h10, 4'hF, 32'hDEADBEEF);
        rd_chk("classic", 0, 32'h10, 32'hDEADBEEF);

        // Byte enables
        wr(0, 32'h20, 4'hF, 32'h11223344);
        wr(0, 32'h20, 4'b0010, 32'h0000AA00);
        rd_chk("byte sel", 0, 32'h20, 32'h1122AA44);

        // Out-of-range access aliases word 0 in the low bits; it must not write
        wr(0, 32'h0, 4'hF, 32'hCAFEF00D);
        tgt = 0; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0001_0000; sel = 4'hF; dat = 32'h12345678;
        @(negedge clk);
        check("err c0", {31'd0, err0}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("err c1 err", {31'd0, err0}, 32'd1);
        check("err c1 ack", {31'd0, ack0}, 32'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("err one cycle", {31'd0, err0}, 32'd0);
        bus_idle(1);
        rd_chk("err no write", 0, 32'h0, 32'hCAFEF00D);

        // Wrap4 burst with two wait states: words 6,7,4,5
        for (int i = 4; i < 8; i++) wr(2, 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i));
        exp_dat = '{32'h0, 32'h0, 32'h0, 32'hA0000006, 32'hA0000007, 32'hA0000004, 32'hA0000005, 32'h0};
        exp_ack = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tgt = 2; we = 1'b0; adr = 32'h18; sel = 4'hF; bte = 2'b01;
        for (int k = 0; k < 8; k++) begin
            cyc = (k <= 6);
            stb = (k <= 6);
            cti = (k == 6) ? 3'b111 : 3'b010;
            @(negedge clk);
            check($sformatf("wrap4 ack c%0d", k), {31'd0, ack2}, {31'd0, exp_ack[k]});
            if (exp_ack[k]) check($sformatf("wrap4 dat c%0d", k), dat2, exp_dat[k]);
            @(posedge clk); #1;
        end
        bus_idle(1);

        // Linear burst with a two-cycle strobe stall, zero wait states
        for (int i = 5; i < 8; i++) wr(0, 32'(i * 4), 4'hF, 32'hB000_0000 + 32'(i));
        exp_dat = '{32'h0, 32'hDEADBEEF, 32'hB0000005, 32'hB0000006, 32'hB0000006,
                    32'hB0000006, 32'hB0000007, 32'h0};
        exp_ack = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tgt = 0; we = 1'b0; adr = 32'h10; sel = 4'hF; bte = 2'b00;
        for (int k = 0; k < 8; k++) begin
            cyc = (k <= 6);
            stb = (k <= 6) && (k != 3) && (k != 4);
            cti = (k == 6) ? 3'b111 : 3'b010;
            @(negedge clk);
            check($sformatf("stall ack c%0d", k), {31'd0, ack0}, {31'd0, exp_ack[k]});
            if (k >= 1 && k <= 6) check($sformatf("stall dat c%0d", k), dat0, exp_dat[k]);
            @(posedge clk); #1;
        end
        bus_idle(1);

        // Write burst abandoned by dropping cyc: second beat must not land
        tgt = 0; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h14; sel = 4'hF;
        cti = 3'b010; bte = 2'b00; dat = 32'h55555555;
        @(negedge clk);
        check("abort c0 ack", {31'd0, ack0}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort c1 ack", {31'd0, ack0}, 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0; dat = 32'h66666666;
        @(negedge clk);
        check("abort c2 ack", {31'd0, ack0}, 32'd0);
        bus_idle(2);
        rd_chk("abort w5", 0, 32'h14, 32'h55555555);
        rd_chk("abort w6", 0, 32'h18, 32'hB0000006);

        // Asynchronous reset in the middle of a burst
        tgt = 2; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h18; sel = 4'hF;
        cti = 3'b010; bte = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst pre ack", {31'd0, ack2}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst ack", {31'd0, ack2}, 32'd0);
        check("rst err", {31'd0, err2}, 32'd0);
        check("rst dat", dat2, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_idle(2);
        rd_chk("rst keep w6", 2, 32'h18, 32'hA0000006);
        rd_chk("rst keep w0", 0, 32'h10, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
